// File: rtl/board_engine_pkg.sv
// Shared piece, opcode and status encodings plus the standard 8x8 start position.
package board_engine_pkg;

    // Piece types (low three bits of a square); colour is the square MSB.
    localparam logic [2:0] PT_EMPTY  = 3'd0;
    localparam logic [2:0] PT_PAWN   = 3'd1;
    localparam logic [2:0] PT_KNIGHT = 3'd2;
    localparam logic [2:0] PT_BISHOP = 3'd3;
    localparam logic [2:0] PT_ROOK   = 3'd4;
    localparam logic [2:0] PT_QUEEN  = 3'd5;
    localparam logic [2:0] PT_KING   = 3'd6;

    localparam logic       COL_WHITE = 1'b0;
    localparam logic       COL_BLACK = 1'b1;

    // Command opcodes.
    localparam logic [1:0] OP_MOVE = 2'd0;
    localparam logic [1:0] OP_UNDO = 2'd1;
    localparam logic [1:0] OP_NEW  = 2'd2;

    // Completion status codes.
    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_ERR_EMPTY = 3'd1;
    localparam logic [2:0] ST_ERR_TURN  = 3'd2;
    localparam logic [2:0] ST_ERR_SAME  = 3'd3;
    localparam logic [2:0] ST_ERR_RANGE = 3'd4;
    localparam logic [2:0] ST_ERR_HIST  = 3'd5;
    localparam logic [2:0] ST_ERR_OP    = 3'd6;

    // Back-rank piece types, file a at bits [3:0]: R N B Q K B N R.
    localparam logic [31:0] STD_BACK_RANK = 32'h4236_5324;

    // Standard start position as a 4-bit {colour, type} code for square idx.
    function automatic logic [3:0] std_square(input int unsigned idx);
        logic [31:0] back;
        logic [3:0]  code;
        int unsigned rank;
        int unsigned file;
        back = STD_BACK_RANK;
        rank = idx / 8;
        file = idx % 8;
        code = 4'h0;
        case (rank)
            0: code = {COL_WHITE, back[file*4 +: 3]};
            1: code = {COL_WHITE, PT_PAWN};
            6: code = {COL_BLACK, PT_PAWN};
            7: code = {COL_BLACK, back[file*4 +: 3]};
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/board_engine_if.sv
// Command handshake between the command source and the board engine.
interface board_engine_if #(
    parameter int SQ_W = 6
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [SQ_W-1:0] cmd_src;
    logic [SQ_W-1:0] cmd_dst;
    logic            done;
    logic [2:0]      status;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, done, status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, done, status
    );
endinterface

// File: rtl/board_engine_move_history.sv
// Circular undo stack: push overwrites the oldest entry when full, pop walks back.
module move_history #(
    parameter int HIST_DEPTH = 16,
    parameter int ENTRY_W    = 20,
    localparam int PTR_W     = $clog2(HIST_DEPTH)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] top_data,
    output logic [ENTRY_W-1:0] next_data,
    output logic [PTR_W:0]     count
);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(HIST_DEPTH);

    logic [ENTRY_W-1:0] mem [HIST_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;

    // Pointer and occupancy; count saturates so the oldest entry is dropped silently.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - PTR_ONE;
            count  <= count - 1'b1;
        end
    end

    // Entry storage; no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (reset && !clear && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign top_data  = mem[wr_ptr - PTR_ONE];
    assign next_data = mem[wr_ptr - PTR_TWO];

endmodule

// File: rtl/board_engine.sv
// Board-state engine: holds the board, applies MOVE / UNDO / NEW_GAME commands.
module board_engine
    import board_engine_pkg::*;
#(
    parameter int FILES       = 8,
    parameter int RANKS       = 8,
    parameter int PIECE_W     = 4,
    parameter int HIST_DEPTH  = 16,
    parameter int INIT_STD    = 1,
    parameter int STRICT_TURN = 1,
    localparam int NSQ        = FILES * RANKS,
    localparam int SQ_W       = $clog2(NSQ),
    localparam int HC_W       = $clog2(HIST_DEPTH) + 1,
    localparam int LM_W       = 2 * SQ_W + PIECE_W
)(
    input  logic                     clk,
    input  logic                     reset,
    board_engine_if.slave            cmd,
    output logic [NSQ*PIECE_W-1:0]   board,
    output logic                     side,
    output logic [HC_W-1:0]          hist_count,
    output logic [LM_W-1:0]          last_move
);
    localparam int HE_W = 2 * SQ_W + 2 * PIECE_W;
    localparam logic [SQ_W:0] NSQ_V = (SQ_W+1)'(NSQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_UNDO  = 3'd3;
    localparam logic [2:0] S_INIT  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]         state;
    logic               ready_q;
    logic               done_q;
    logic [2:0]         status_q;
    logic [1:0]         op_q;
    logic [SQ_W-1:0]    src_q;
    logic [SQ_W-1:0]    dst_q;
    logic [PIECE_W-1:0] sq [NSQ];
    logic [PIECE_W-1:0] src_pc;
    logic [PIECE_W-1:0] dst_pc;
    logic               chk_err;
    logic [2:0]         chk_st;
    logic [HE_W-1:0]    h_top;
    logic [HE_W-1:0]    h_next;
    logic [SQ_W-1:0]    h_src;
    logic [SQ_W-1:0]    h_dst;
    logic [PIECE_W-1:0] h_cap;
    logic [PIECE_W-1:0] h_moved;

    // Initial contents of square i; standard setup only exists for an 8x8 board.
    function automatic logic [PIECE_W-1:0] init_sq(input int unsigned i);
        logic [3:0]         code;
        logic [PIECE_W-1:0] r;
        r = '0;
        if (INIT_STD != 0 && FILES == 8 && RANKS == 8) begin
            code = std_square(i);
            r[PIECE_W-1] = code[3];
            r[2:0]       = code[2:0];
        end
        return r;
    endfunction

    assign src_pc  = sq[src_q];
    assign dst_pc  = sq[dst_q];
    assign h_src   = h_top[HE_W-1 -: SQ_W];
    assign h_dst   = h_top[HE_W-SQ_W-1 -: SQ_W];
    assign h_cap   = h_top[2*PIECE_W-1 -: PIECE_W];
    assign h_moved = h_top[PIECE_W-1:0];

    assign cmd.cmd_ready = ready_q;
    assign cmd.done      = done_q;
    assign cmd.status    = status_q;

    move_history #(
        .HIST_DEPTH (HIST_DEPTH),
        .ENTRY_W    (HE_W)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == S_INIT),
        .push      (state == S_APPLY),
        .pop       (state == S_UNDO),
        .push_data ({src_q, dst_q, dst_pc, src_pc}),
        .top_data  (h_top),
        .next_data (h_next),
        .count     (hist_count)
    );

    // Command validation in priority order on the latched command.
    always_comb begin
        chk_err = 1'b1;
        chk_st  = ST_ERR_OP;
        case (op_q)
            OP_MOVE: begin
                if (({1'b0, src_q} >= NSQ_V) || ({1'b0, dst_q} >= NSQ_V)) begin
                    chk_st = ST_ERR_RANGE;
                end else if (src_q == dst_q) begin
                    chk_st = ST_ERR_SAME;
                end else if (src_pc[2:0] == PT_EMPTY) begin
                    chk_st = ST_ERR_EMPTY;
                end else if (STRICT_TURN != 0 && src_pc[PIECE_W-1] != side) begin
                    chk_st = ST_ERR_TURN;
                end else begin
                    chk_err = 1'b0;
                    chk_st  = ST_OK;
                end
            end
            OP_UNDO: begin
                if (hist_count == '0) begin
                    chk_st = ST_ERR_HIST;
                end else begin
                    chk_err = 1'b0;
                    chk_st  = ST_OK;
                end
            end
            OP_NEW: begin
                chk_err = 1'b0;
                chk_st  = ST_OK;
            end
            default: begin
                chk_err = 1'b1;
                chk_st  = ST_ERR_OP;
            end
        endcase
    end

    // Control FSM, handshake, side-to-move and last_move registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            status_q  <= ST_OK;
            side      <= COL_WHITE;
            last_move <= '0;
            op_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid && ready_q) begin
                        op_q    <= cmd.cmd_op;
                        src_q   <= cmd.cmd_src;
                        dst_q   <= cmd.cmd_dst;
                        ready_q <= 1'b0;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err) begin
                        status_q <= chk_st;
                        done_q   <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        case (op_q)
                            OP_MOVE: state <= S_APPLY;
                            OP_UNDO: state <= S_UNDO;
                            default: state <= S_INIT;
                        endcase
                    end
                end
                S_APPLY: begin
                    side      <= ~side;
                    last_move <= {src_q, dst_q, dst_pc};
                    status_q  <= ST_OK;
                    done_q    <= 1'b1;
                    state     <= S_RESP;
                end
                S_UNDO: begin
                    side      <= ~side;
                    // After the pop the new top is the entry below the current one.
                    last_move <= (hist_count > HC_W'(1)) ? h_next[HE_W-1 -: LM_W] : '0;
                    status_q  <= ST_OK;
                    done_q    <= 1'b1;
                    state     <= S_RESP;
                end
                S_INIT: begin
                    side      <= COL_WHITE;
                    last_move <= '0;
                    status_q  <= ST_OK;
                    done_q    <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Board square registers, updated by APPLY, UNDO and INIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NSQ; i++) begin
                sq[i] <= init_sq(i);
            end
        end else begin
            case (state)
                S_APPLY: begin
                    sq[dst_q] <= src_pc;
                    sq[src_q] <= '0;
                end
                S_UNDO: begin
                    sq[h_src] <= h_moved;
                    sq[h_dst] <= h_cap;
                end
                S_INIT: begin
                    for (int unsigned i = 0; i < NSQ; i++) begin
                        sq[i] <= init_sq(i);
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the square array onto the board bus.
    always_comb begin
        board = '0;
        for (int unsigned i = 0; i < NSQ; i++) begin
            board[i*PIECE_W +: PIECE_W] = sq[i];
        end
    end

endmodule
